// File: rtl/sram_arb_pkg.sv
// Shared types and phase constants for the time-slotted SRAM arbiter.
// The SRAM cycle is 8 clkPhase counts split into two 4-clock slots.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic {
    SLOT_A = 1'b0,
    SLOT_B = 1'b1
  } slot_t;

  // Decision phases: sampling phase 7 opens slot A, phase 3 opens slot B.
  localparam logic [2:0] DEC_A     = 3'd7;
  localparam logic [2:0] DEC_B     = 3'd3;
  localparam logic [2:0] WE_FALL_K = 3'd1;
  localparam logic [2:0] WE_RISE_K = 3'd3;
  localparam logic [2:0] CAPTURE_K = 3'd3;

  function automatic logic is_decision(input logic [2:0] phase);
    return (phase == DEC_A) || (phase == DEC_B);
  endfunction

endpackage

// File: rtl/sram_arb_sched.sv
// Combinational slot scheduler: picks the winner of the slot that opens at
// the current decision edge. Reads are favoured in slot A, writes in slot B.
module sram_arb_sched
  import sram_arb_pkg::*;
(
  input  logic [2:0] clkPhase,
  input  logic       reset,
  input  logic       rd_valid,
  input  logic       wr_valid,
  output logic       rd_ready,
  output logic       wr_ready,
  output state_t     grant
);

  slot_t slot;

  always_comb begin
    slot  = (clkPhase == DEC_A) ? SLOT_A : SLOT_B;
    grant = IDLE;
    if (!reset && is_decision(clkPhase)) begin
      if (slot == SLOT_A) begin
        if (rd_valid)      grant = READ;
        else if (wr_valid) grant = WRITE;
      end else begin
        if (wr_valid)      grant = WRITE;
        else if (rd_valid) grant = READ;
      end
    end
    rd_ready = (grant == READ);
    wr_ready = (grant == WRITE);
  end

endmodule

// File: rtl/sram_arbiter.sv
// Time-slotted read/write arbiter for a 256Kx16 asynchronous SRAM; every pad
// signal is a flop. Optional byte-lane writes: SRAM_ARB_BYTE_MASK_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        clkPhase,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  state_t            state_q, state_d;
  state_t            grant;
  logic [2:0]        k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_data_valid_q, rd_data_valid_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;
  logic [1:0]        wr_byte_n;

`ifdef SRAM_ARB_BYTE_MASK_EN
  assign wr_byte_n = ~wr_be;
`else
  logic unused_wr_be;
  assign unused_wr_be = ^wr_be;
  assign wr_byte_n    = 2'b00;
`endif

  sram_arb_sched u_sched (
    .clkPhase (clkPhase),
    .reset    (reset),
    .rd_valid (rd_valid),
    .wr_valid (wr_valid),
    .rd_ready (rd_ready),
    .wr_ready (wr_ready),
    .grant    (grant)
  );

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    addr_d          = addr_q;
    dq_o_d          = dq_o_q;
    dq_oe_d         = dq_oe_q;
    ce_n_d          = ce_n_q;
    oe_n_d          = oe_n_q;
    we_n_d          = we_n_q;
    ub_n_d          = ub_n_q;
    lb_n_d          = lb_n_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = 1'b0;

    // k_q names the offset of the upcoming edge relative to the grant edge.
    if (state_q != IDLE) k_d = k_q + 3'd1;

    case (state_q)
      WRITE: begin
        if (k_q == WE_FALL_K) we_n_d = 1'b0;
        if (k_q == WE_RISE_K) we_n_d = 1'b1;
      end
      READ: begin
        if (k_q == CAPTURE_K) begin
          rd_data_d       = sram_dq_i;
          rd_data_valid_d = 1'b1;
          oe_n_d          = 1'b1;
        end
      end
      default: ;
    endcase

    if (is_decision(clkPhase)) begin
      case (grant)
        READ: begin
          state_d = READ;
          k_d     = 3'd1;
          addr_d  = rd_addr;
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          ub_n_d  = 1'b0;
          lb_n_d  = 1'b0;
        end
        WRITE: begin
          state_d = WRITE;
          k_d     = 3'd1;
          addr_d  = wr_addr;
          dq_o_d  = wr_data;
          dq_oe_d = 1'b1;
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          ub_n_d  = wr_byte_n[1];
          lb_n_d  = wr_byte_n[0];
        end
        default: begin
          state_d = IDLE;
          k_d     = 3'd0;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          ub_n_d  = 1'b1;
          lb_n_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      k_q             <= 3'd0;
      addr_q          <= '0;
      dq_o_q          <= '0;
      dq_oe_q         <= 1'b0;
      ce_n_q          <= 1'b1;
      oe_n_q          <= 1'b1;
      we_n_q          <= 1'b1;
      ub_n_q          <= 1'b1;
      lb_n_q          <= 1'b1;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      addr_q          <= addr_d;
      dq_o_q          <= dq_o_d;
      dq_oe_q         <= dq_oe_d;
      ce_n_q          <= ce_n_d;
      oe_n_q          <= oe_n_d;
      we_n_q          <= we_n_d;
      ub_n_q          <= ub_n_d;
      lb_n_q          <= lb_n_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
    end
  end

  assign sram_addr     = addr_q;
  assign sram_dq_o     = dq_o_q;
  assign sram_dq_oe    = dq_oe_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_ub_n     = ub_n_q;
  assign sram_lb_n     = lb_n_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: an SRAM pad model, a slot/timing reference
// model checked every cycle, and literal expectations per scenario.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

`ifdef SRAM_ARB_BYTE_MASK_EN
  localparam bit BYTE_MASK = 1'b1;
`else
  localparam bit BYTE_MASK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic [2:0]    clk_phase = 3'd0;
  logic          reset;
  logic          rd_valid, wr_valid;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_be;
  logic          rd_ready, wr_ready, rd_data_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) clk_phase <= clk_phase + 3'd1;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .clkPhase(clk_phase),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ready(wr_ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM pad model ----------------
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  bit            sram_written [0:(1<<AW)-1];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 18'h00123) ? 16'hBEEF : 16'hFFFF;
  endfunction

  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    return sram_written[a] ? sram_mem[a] : init_word(a);
  endfunction

  always_comb sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_word(sram_addr) : 16'hDEAD;

  always @(negedge clk) begin : sram_wr
    logic [DW-1:0] w;
    if (!sram_ce_n && !sram_we_n) begin
      w = sram_word(sram_addr);
      if (!sram_ub_n) w[15:8] = sram_dq_oe ? sram_dq_o[15:8] : 8'hDE;
      if (!sram_lb_n) w[7:0]  = sram_dq_oe ? sram_dq_o[7:0]  : 8'hAD;
      sram_mem[sram_addr]     = w;
      sram_written[sram_addr] = 1'b1;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [DW-1:0] exp_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_get(input logic [AW-1:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
  endfunction

  int            m_kind = 0;   // 0 idle, 1 read, 2 write
  int            m_age = 0;    // edges since the grant edge
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_dq_o = '0, m_rd_data = '0;
  logic [1:0]    m_be = 2'b11;
  logic          m_rdv = 1'b0;
  bit            started = 1'b0;
  int rd_acc = 0, wr_acc = 0, oe_low = 0, we_low = 0, dq_oe_hi = 0, rdv_cnt = 0, overlap = 0;

  always @(negedge clk) begin : model_p
    logic dec, e_rrdy, e_wrdy, e_ce_n, e_oe_n, e_we_n, e_dq_oe;
    logic [1:0] e_bn;
    logic [DW-1:0] w;
    if (started) begin
      e_ce_n  = (m_kind == 0);
      e_oe_n  = !(m_kind == 1 && m_age <= 2);
      e_we_n  = !(m_kind == 2 && (m_age == 1 || m_age == 2));
      e_dq_oe = (m_kind == 2);
      if (m_kind == 0)      e_bn = 2'b11;
      else if (m_kind == 1) e_bn = 2'b00;
      else                  e_bn = BYTE_MASK ? ~m_be : 2'b00;
      chk("ce_n", 32'(sram_ce_n), 32'(e_ce_n));
      chk("oe_n", 32'(sram_oe_n), 32'(e_oe_n));
      chk("we_n", 32'(sram_we_n), 32'(e_we_n));
      chk("dq_oe", 32'(sram_dq_oe), 32'(e_dq_oe));
      chk("ub_lb_n", 32'({sram_ub_n, sram_lb_n}), 32'(e_bn));
      chk("rd_data_valid", 32'(rd_data_valid), 32'(m_rdv));
      chk("rd_data", 32'(rd_data), 32'(m_rd_data));
      chk("sram_addr", 32'(sram_addr), 32'(m_addr));
      chk("sram_dq_o", 32'(sram_dq_o), 32'(m_dq_o));
    end
    if (!sram_oe_n) oe_low++;
    if (!sram_we_n) we_low++;
    if (sram_dq_oe) dq_oe_hi++;
    if (rd_data_valid) rdv_cnt++;
    if (!sram_oe_n && !sram_we_n) overlap++;
    if (rd_ready && rd_valid) rd_acc++;
    if (wr_ready && wr_valid) wr_acc++;

    dec    = !reset && (clk_phase == 3'd3 || clk_phase == 3'd7);
    e_rrdy = dec && ((clk_phase == 3'd7) ? rd_valid : (rd_valid && !wr_valid));
    e_wrdy = dec && ((clk_phase == 3'd3) ? wr_valid : (wr_valid && !rd_valid));
    chk("rd_ready", 32'(rd_ready), 32'(e_rrdy));
    chk("wr_ready", 32'(wr_ready), 32'(e_wrdy));

    // advance the model to the state after the coming edge
    m_rdv = 1'b0;
    if (reset) begin
      m_kind = 0; m_age = 0; m_addr = '0; m_dq_o = '0; m_rd_data = '0; m_be = 2'b11;
      started = 1'b1;
    end else begin
      if (m_kind != 0) m_age++;
      if (m_kind == 1 && m_age == 3) begin
        m_rd_data = mem_get(m_addr);
        m_rdv     = 1'b1;
      end
      if (e_rrdy) begin
        m_kind = 1; m_age = 0; m_addr = rd_addr;
      end else if (e_wrdy) begin
        m_kind = 2; m_age = 0; m_addr = wr_addr; m_dq_o = wr_data; m_be = wr_be;
        w = mem_get(wr_addr);
        if (!BYTE_MASK || wr_be[1]) w[15:8] = wr_data[15:8];
        if (!BYTE_MASK || wr_be[0]) w[7:0]  = wr_data[7:0];
        exp_mem[wr_addr] = w;
      end else if (dec) begin
        m_kind = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n;
    n = 0;
    while (clk_phase != p && n < 16) begin
      tick();
      n++;
    end
    if (clk_phase != p) chk("wait_phase_timeout", 32'(clk_phase), 32'(p));
  endtask

  task automatic wait_ready(input bit is_rd, output logic [2:0] ph);
    int n;
    n = 0;
    @(negedge clk);
    while (!(is_rd ? rd_ready : wr_ready) && n < 32) begin
      @(negedge clk);
      n++;
    end
    ph = clk_phase;
    chk(is_rd ? "rd_ready_timeout" : "wr_ready_timeout",
        32'(is_rd ? rd_ready : wr_ready), 32'd1);
    tick();
  endtask

  initial begin
    logic [2:0] ph;
    int s0, s1;
    reset = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = 2'b11;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_strobes", 32'({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'hF);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // single read
    wait_phase(3'd5);
    rd_addr = 18'h00123; rd_valid = 1'b1;
    s0 = oe_low; s1 = rdv_cnt;
    wait_ready(1'b1, ph);
    rd_valid = 1'b0;
    chk("read_accept_phase", 32'(ph), 32'd7);
    repeat (8) tick();
    chk("read_oe_low_cycles", 32'(oe_low - s0), 32'd3);
    chk("read_valid_pulses", 32'(rdv_cnt - s1), 32'd1);
    chk("read_data", 32'(rd_data), 32'hBEEF);
    $display("read  addr=00123 data=%h", rd_data);

    // single write
    wait_phase(3'd1);
    wr_addr = 18'h3FFFF; wr_data = 16'hA55A; wr_be = 2'b11; wr_valid = 1'b1;
    s0 = we_low; s1 = dq_oe_hi;
    wait_ready(1'b0, ph);
    wr_valid = 1'b0;
    chk("write_accept_phase", 32'(ph), 32'd3);
    repeat (8) tick();
    chk("write_we_low_cycles", 32'(we_low - s0), 32'd2);
    chk("write_dq_oe_cycles", 32'(dq_oe_hi - s1), 32'd4);
    chk("write_mem", 32'(sram_word(18'h3FFFF)), 32'hA55A);
    $display("write addr=3ffff mem=%h", sram_word(18'h3FFFF));

    // contention: both valid for 32 clocks
    wait_phase(3'd0);
    rd_addr = 18'h00123; wr_addr = 18'h00200; wr_data = 16'h1111; wr_be = 2'b11;
    rd_valid = 1'b1; wr_valid = 1'b1;
    s0 = rd_acc; s1 = wr_acc;
    repeat (32) tick();
    rd_valid = 1'b0; wr_valid = 1'b0;
    chk("contention_reads", 32'(rd_acc - s0), 32'd4);
    chk("contention_writes", 32'(wr_acc - s1), 32'd4);
    $display("contention reads=%0d writes=%0d", rd_acc - s0, wr_acc - s1);
    repeat (8) tick();

    // opportunistic: writes only for 16 clocks
    wait_phase(3'd0);
    wr_addr = 18'h00300; wr_data = 16'h2222; wr_valid = 1'b1;
    s1 = wr_acc;
    repeat (16) tick();
    wr_valid = 1'b0;
    chk("opportunistic_writes", 32'(wr_acc - s1), 32'd4);
    repeat (8) tick();
    chk("opportunistic_mem", 32'(sram_word(18'h00300)), 32'h2222);
    $display("opportunistic writes=%0d", wr_acc - s1);

    // byte mask write over 0xFFFF, then read back
    wait_phase(3'd1);
    wr_addr = 18'h00400; wr_data = 16'h1234; wr_be = 2'b01; wr_valid = 1'b1;
    wait_ready(1'b0, ph);
    wr_valid = 1'b0; wr_be = 2'b11;
    repeat (8) tick();
    chk("byte_mask_mem", 32'(sram_word(18'h00400)), BYTE_MASK ? 32'hFF34 : 32'h1234);
    rd_addr = 18'h00400; rd_valid = 1'b1;
    wait_ready(1'b1, ph);
    rd_valid = 1'b0;
    repeat (8) tick();
    chk("byte_mask_readback", 32'(rd_data), BYTE_MASK ? 32'hFF34 : 32'h1234);
    $display("byte mask write mem=%h", sram_word(18'h00400));

    // reset at k=2 of a write
    wait_phase(3'd1);
    wr_addr = 18'h00500; wr_data = 16'h5555; wr_valid = 1'b1;
    wait_ready(1'b0, ph);
    wr_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_addr = 18'h00123; rd_valid = 1'b1;
    @(negedge clk);
    chk("midrst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
    chk("midrst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("midrst_rdv", 32'(rd_data_valid), 32'd0);
    wait_ready(1'b1, ph);
    rd_valid = 1'b0;
    chk("post_reset_grant_phase", 32'(ph), 32'd7);
    repeat (8) tick();
    chk("post_reset_read", 32'(rd_data), 32'hBEEF);
    $display("reset mid-write, next read data=%h", rd_data);

    chk("oe_we_overlap", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
